// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dff_bank_arbiter
//  Purpose  : One shared WIDTH-bit register bank written by NUM_REQ
//             requesters. A round-robin arbiter selects a writer, and a
//             three-state sequencer (IDLE -> WRITE -> COOLDOWN) captures
//             that writer's data and then enforces an idle hold-off.
//  Revision : 1.0  initial release
// ============================================================================
module dff_bank_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         q,
  output logic [IDW-1:0]           owner,
  output logic                     q_valid,
  output logic                     busy
);

  // Requester count at the width of the wrap-around sum below.
  localparam logic [IDW:0] C_NUM_REQ_W = (IDW+1)'(NUM_REQ);
  // Starting priority pointer: the last-served slot is the top one, so
  // requester 0 is searched first.
  localparam logic [IDW-1:0] C_LAST_RST = IDW'(NUM_REQ - 1);
  // Cooldown reload value; the counter is 8 bits wide to cover 0..255.
  localparam logic [7:0] C_HOLD = 8'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [WIDTH-1:0]     q_q;
  logic [IDW-1:0]       owner_q;
  logic                 q_valid_q;
  logic                 busy_q;
  logic [IDW-1:0]       sel_q;
  logic [IDW-1:0]       last_q;
  logic [7:0]           cnt_q;

  // Arbitration results, consumed only when the sequencer sits in IDLE.
  logic [IDW-1:0]       sel_d;
  logic                 pick_vld_d;
  logic [NUM_REQ-1:0]   gnt_d;
  logic [IDW:0]         cand;

  // Per-requester view of the packed write data bus.
  logic [WIDTH-1:0]     lane [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Round-robin search: scan last+1, last+2, ... (mod NUM_REQ) and take
  // the first asserted request. The extra sum bit keeps the wrap exact
  // for requester counts that are not a power of two.
  always_comb begin
    pick_vld_d = 1'b0;
    sel_d      = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (IDW+1)'(k);
      if (cand >= C_NUM_REQ_W) begin
        cand = cand - C_NUM_REQ_W;
      end
      if (!pick_vld_d && req[cand[IDW-1:0]]) begin
        pick_vld_d = 1'b1;
        sel_d      = cand[IDW-1:0];
      end
    end
  end

  // One-hot form of the chosen winner, loaded into the grant register.
  always_comb begin
    gnt_d = NUM_REQ'(1) << sel_d;
  end

  // Sequencer: grant in IDLE, capture in WRITE, hold off in COOLDOWN.
  // Every output is a flop so downstream sees glitch-free values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      q_q       <= '0;
      owner_q   <= '0;
      q_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      sel_q     <= '0;
      last_q    <= C_LAST_RST;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= 1'b1;
            state_q <= S_WRITE;
          end
        end

        S_WRITE: begin
          // Data is taken at the end of the grant cycle, and the write
          // proceeds even if the winner has already dropped its request.
          q_q       <= lane[sel_q];
          owner_q   <= sel_q;
          q_valid_q <= 1'b1;
          last_q    <= sel_q;
          gnt_q     <= '0;
          if (HOLD_CYCLES == 0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= C_HOLD;
            state_q <= S_COOLDOWN;
          end
        end

        S_COOLDOWN: begin
          // Requests are not looked at here; they wait for the next IDLE.
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign owner   = owner_q;
  assign q_valid = q_valid_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_bank_arbiter
//  Purpose  : Directed self-checking bench for dff_bank_arbiter. One
//             instance uses a two-cycle hold-off, a second one uses none.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dff_bank_arbiter;

  logic        clk;
  logic        areset;

  // Instance with HOLD_CYCLES = 2
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        q_valid;
  logic        busy;

  // Instance with HOLD_CYCLES = 0
  logic [3:0]  req0;
  logic [31:0] wdata0;
  logic [3:0]  gnt0;
  logic [7:0]  q0;
  logic [1:0]  owner0;
  logic        q_valid0;
  logic        busy0;

  int n_total;
  int n_bad;

  dff_bank_arbiter #(
    .NUM_REQ     (4),
    .WIDTH       (8),
    .HOLD_CYCLES (2)
  ) dut (
    .clk     (clk),
    .areset  (areset),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .owner   (owner),
    .q_valid (q_valid),
    .busy    (busy)
  );

  dff_bank_arbiter #(
    .NUM_REQ     (4),
    .WIDTH       (8),
    .HOLD_CYCLES (0)
  ) dut0 (
    .clk     (clk),
    .areset  (areset),
    .req     (req0),
    .wdata   (wdata0),
    .gnt     (gnt0),
    .q       (q0),
    .owner   (owner0),
    .q_valid (q_valid0),
    .busy    (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges.
  task automatic pulse_reset();
    #2 areset = 1'b1;
    #2 areset = 1'b0;
  endtask

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] seen;
  logic [3:0] exp_g0 [6];

  initial begin
    n_total = 0;
    n_bad   = 0;
    areset  = 1'b0;
    req     = '0;
    wdata   = '0;
    req0    = '0;
    wdata0  = '0;

    // ---------------- reset check ----------------
    #2 areset = 1'b1;
    #1;
    chk("rst_gnt",     32'(gnt),     32'h0);
    chk("rst_q",       32'(q),       32'h0);
    chk("rst_owner",   32'(owner),   32'h0);
    chk("rst_qvalid",  32'(q_valid), 32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    @(negedge clk);
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_gnt",  32'(gnt),  32'h0);
    end
    chk("idle_qvalid", 32'(q_valid), 32'h0);
    chk("idle_q",      32'(q),       32'h0);

    // ---------------- single request ----------------
    req          = 4'b0001;
    wdata[7:0]   = 8'hA5;
    tick();
    chk("single_gnt",  32'(gnt),  32'h1);
    chk("single_busy1", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    chk("single_q",      32'(q),       32'hA5);
    chk("single_owner",  32'(owner),   32'h0);
    chk("single_qvalid", 32'(q_valid), 32'h1);
    chk("single_gnt_off", 32'(gnt),    32'h0);
    chk("single_busy2",  32'(busy),    32'h1);
    tick();
    chk("single_busy3",  32'(busy),    32'h1);
    tick();
    chk("single_busy4",  32'(busy),    32'h0);

    // ---------------- round-robin, all requesting ----------------
    pulse_reset();
    wdata = 32'h13121110;
    req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gnt",  32'(gnt), 32'(4'b0001 << (g % 4)));
      tick();
      chk("rr_q",    32'(q),   32'(8'h10 + (g % 4)));
      chk("rr_own",  32'(owner), 32'(g % 4));
      tick();
      chk("rr_gap1", 32'(gnt), 32'h0);
      tick();
      chk("rr_gap2", 32'(gnt), 32'h0);
    end
    req = 4'b0000;

    // ---------------- wrap and skip ----------------
    // last = 0 here; requester 2 is the only one asking.
    req = 4'b0100;
    tick();
    chk("ws_gnt2", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick();
    chk("ws_own2", 32'(owner), 32'h2);
    tick();
    tick();
    req = 4'b0011;
    tick();
    chk("ws_gnt_a", 32'(gnt), 32'h1);
    tick(); tick(); tick();
    tick();
    chk("ws_gnt_b", 32'(gnt), 32'h2);
    tick(); tick(); tick();
    tick();
    chk("ws_gnt_c", 32'(gnt), 32'h1);
    tick(); tick(); tick();
    req = 4'b0000;

    // ---------------- request dropped during grant ----------------
    req          = 4'b0100;
    wdata[23:16] = 8'h3C;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick();
    chk("drop_q",   32'(q),     32'h3C);
    chk("drop_own", 32'(owner), 32'h2);
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | gnt;
    end
    chk("drop_no_more_gnt", 32'(seen), 32'h0);
    chk("drop_busy",        32'(busy), 32'h0);

    // ---------------- reset during WRITE ----------------
    req = 4'b0010;
    tick();
    chk("mw_gnt", 32'(gnt), 32'h2);
    #2 areset = 1'b1;
    #1;
    chk("mw_q",      32'(q),       32'h0);
    chk("mw_qvalid", 32'(q_valid), 32'h0);
    chk("mw_gnt0",   32'(gnt),     32'h0);
    chk("mw_busy",   32'(busy),    32'h0);
    chk("mw_owner",  32'(owner),   32'h0);
    #1 areset = 1'b0;
    req          = 4'b1010;
    wdata[15:8]  = 8'h5A;
    wdata[31:24] = 8'h77;
    tick();
    chk("mw_first_gnt", 32'(gnt), 32'h2);
    req = 4'b1000;
    tick();
    chk("mw_q1",   32'(q),     32'h5A);
    chk("mw_own1", 32'(owner), 32'h1);
    tick();
    tick();
    tick();
    chk("mw_next_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick();
    chk("mw_q3",   32'(q),     32'h77);
    chk("mw_own3", 32'(owner), 32'h3);

    // ---------------- zero hold-off instance ----------------
    exp_g0[0] = 4'b0001;
    exp_g0[1] = 4'b0000;
    exp_g0[2] = 4'b0010;
    exp_g0[3] = 4'b0000;
    exp_g0[4] = 4'b0001;
    exp_g0[5] = 4'b0000;
    wdata0 = 32'h0000B1B0;
    req0   = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("h0_gnt", 32'(gnt0), 32'(exp_g0[i]));
      chk("h0_busy", 32'(busy0), 32'((i % 2) == 0));
      if (i == 1) chk("h0_q_a", 32'(q0), 32'hB0);
      if (i == 3) chk("h0_q_b", 32'(q0), 32'hB1);
    end
    chk("h0_qvalid", 32'(q_valid0), 32'h1);
    chk("h0_owner",  32'(owner0),   32'h0);
    req0 = 4'b0000;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
